// File: rtl/argmin_pkg.sv
// argmin_pkg
// Shared definitions for the sequential argmin search block and the ghost
// movement controller that consumes its result.
//   state_t           : search FSM states (IDLE, SCAN, DONE)
//   DEFAULT_DATA_W    : default candidate width
//   DEFAULT_NUM_CAND  : default number of candidates per search
//   DIR_*             : candidate index of each movement direction
package argmin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_CAND = 4;

  // Candidates arrive in this order, so index 0 wins ties.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

endpackage

// File: rtl/seq_argmin_if.sv
// seq_argmin_if
// Handshake bundle between the distance calculator (candidate beats), the
// argmin block and the movement controller (result).
//   start, mode_max                 : search launch and min/max select
//   in_valid/in_ready/in_data/
//   in_blocked                      : candidate beat stream
//   res_valid/res_ready/res_idx/
//   res_val/res_none                : result handshake
//   busy                            : search in progress
// Modports: master drives the launch, candidates and res_ready;
//           slave is the argmin block.
interface seq_argmin_if import argmin_pkg::*; #(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_CAND = DEFAULT_NUM_CAND
);
  localparam int IDX_W = $clog2(NUM_CAND);

  logic              start;
  logic              mode_max;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_blocked;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_idx;
  logic [DATA_W-1:0] res_val;
  logic              res_none;
  logic              busy;

  modport master (
    output start, mode_max, in_valid, in_data, in_blocked, res_ready,
    input  in_ready, res_valid, res_idx, res_val, res_none, busy
  );

  modport slave (
    input  start, mode_max, in_valid, in_data, in_blocked, res_ready,
    output in_ready, res_valid, res_idx, res_val, res_none, busy
  );

endinterface

// File: rtl/argmin_cmp.sv
// argmin_cmp
// Combinational "better-than" test for the argmin search.
//   a        : incoming candidate value
//   b        : current best value
//   max_mode : 1 selects maximum search (only with SEQ_ARGMIN_MAX_MODE_EN)
//   take     : candidate strictly beats the current best
// Macro SEQ_ARGMIN_MAX_MODE_EN: when undefined the comparator is a plain
// strict less-than and max_mode is ignored.
module argmin_cmp #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              max_mode,
  output logic              take
);

  // Strict compares so equal values never displace an earlier candidate.
`ifdef SEQ_ARGMIN_MAX_MODE_EN
  assign take = max_mode ? (a > b) : (a < b);
`else
  logic unused_max_mode;
  assign unused_max_mode = max_mode;
  assign take = (a < b);
`endif

endmodule

// File: rtl/seq_argmin.sv
// seq_argmin
// Scans NUM_CAND candidate values, one per accepted beat, and reports the
// index and value of the smallest unblocked candidate (or the largest, in
// max mode). Ties keep the lower index.
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset
//   bus     : seq_argmin_if slave (launch, candidate stream, result)
// Macro SEQ_ARGMIN_MAX_MODE_EN: enables the mode_max latch so a search can
// select the maximum; when undefined mode_max is ignored.
module seq_argmin import argmin_pkg::*; #(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_CAND = DEFAULT_NUM_CAND
) (
  input logic         Clk,
  input logic         Reset_n,
  seq_argmin_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_CAND);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_t            state;
  logic [IDX_W-1:0]  count;
  logic              have_best;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best_val;
  logic              mode_q;
  logic              better;
  logic              accept;
  logic              take;

  // Max-mode selection is captured once per search so the consumer can
  // change mode_max freely while the scan runs.
`ifdef SEQ_ARGMIN_MAX_MODE_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      mode_q <= bus.mode_max;
    end
  end
`else
  logic unused_mode_max;
  assign unused_mode_max = bus.mode_max;
  assign mode_q          = 1'b0;
`endif

  argmin_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a        (bus.in_data),
    .b        (best_val),
    .max_mode (mode_q),
    .take     (better)
  );

  assign accept = bus.in_valid && (state == SCAN);
  // The first unblocked candidate always wins, whatever best_val holds.
  assign take   = accept && !bus.in_blocked && (!have_best || better);

  // Search FSM, beat counter and running best.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      count     <= '0;
      have_best <= 1'b0;
      best_idx  <= '0;
      best_val  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= SCAN;
            count     <= '0;
            have_best <= 1'b0;
            best_idx  <= '0;
            best_val  <= '0;
          end
        end
        SCAN: begin
          if (accept) begin
            if (take) begin
              have_best <= 1'b1;
              best_idx  <= count;
              best_val  <= bus.in_data;
            end
            if (count == LAST_IDX) begin
              count <= '0;
              state <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from state. With every candidate
  // blocked best_idx/best_val were never written after start, so they read 0.
  assign bus.in_ready  = (state == SCAN);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_none  = (state == DONE) && !have_best;
  assign bus.res_idx   = best_idx;
  assign bus.res_val   = best_val;

endmodule

// File: tb/tb_seq_argmin.sv
// tb_seq_argmin
// Directed bench for seq_argmin with the default 4 x 32-bit configuration.
// A scoreboard queue holds the result each search should produce; it is
// filled when the search is driven and drained when res_valid appears.
module tb_seq_argmin;
  import argmin_pkg::*;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] val;
    logic        none;
  } res_t;

  logic  clk;
  logic  reset_n;
  int    compared;
  int    mismatched;
  res_t  exp_q[$];
  logic [31:0] stim_data [4];
  bit          stim_blk  [4];

  seq_argmin_if bus ();

  seq_argmin dut (
    .Clk     (clk),
    .Reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: strict compare in arrival order, blocked beats skipped.
  function automatic res_t modelSearch(input bit mode);
    res_t e;
    bit   have;
    bit   wins;
    e    = '0;
    have = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stim_blk[i]) begin
`ifdef SEQ_ARGMIN_MAX_MODE_EN
        wins = mode ? (stim_data[i] > e.val) : (stim_data[i] < e.val);
`else
        wins = (stim_data[i] < e.val);
`endif
        if (!have || wins) begin
          have  = 1'b1;
          e.idx = i[1:0];
          e.val = stim_data[i];
        end
      end
    end
    e.none = !have;
    return e;
  endfunction

  // One full search: launch, four beats (optionally with bubbles and a
  // stray start), then a result held for 'hold' cycles before res_ready.
  task automatic applyStimulus(input bit mode, input int bubbles,
                               input int hold, input bit poke_start);
    res_t got;
    int   waited;
    exp_q.push_back(modelSearch(mode));

    bus.start    = 1'b1;
    bus.mode_max = mode;
    tick();
    bus.start    = 1'b0;
    bus.mode_max = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
    checkOutput("in_ready_scan", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < bubbles; b++) begin
        bus.in_valid = 1'b0;
        tick();
        checkOutput("bubble_in_ready", bus.in_ready, 1);
      end
      bus.in_valid   = 1'b1;
      bus.in_data    = stim_data[i];
      bus.in_blocked = stim_blk[i];
      bus.start      = poke_start && (i == 1);
      tick();
      bus.in_valid   = 1'b0;
      bus.in_blocked = 1'b0;
      bus.start      = 1'b0;
      if (i < 3) checkOutput("no_early_valid", bus.res_valid, 0);
    end
    checkOutput("res_valid_latency", bus.res_valid, 1);

    waited = 0;
    while (!bus.res_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (waited != 0) checkOutput("res_valid_timeout", bus.res_valid, 1);

    got = exp_q.pop_front();
    bus.res_ready = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      checkOutput("res_valid_hold", bus.res_valid, 1);
      checkOutput("res_idx", bus.res_idx, got.idx);
      checkOutput("res_val", bus.res_val, got.val);
      checkOutput("res_none", bus.res_none, got.none);
      if (h < hold) begin
        bus.start = poke_start;
        tick();
        bus.start = 1'b0;
      end
    end

    bus.res_ready = 1'b1;
    bus.start     = poke_start;
    tick();
    bus.res_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("res_valid_drop", bus.res_valid, 0);
    checkOutput("busy_idle", bus.busy, 0);
    tick();
    checkOutput("idle_stays", bus.busy, 0);
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.mode_max   = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_blocked = 1'b0;
    bus.res_ready  = 1'b0;

    #12;
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_res_idx", bus.res_idx, 0);
    checkOutput("rst_res_val", bus.res_val, 0);
    checkOutput("rst_res_none", bus.res_none, 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] basic minimum");
    stim_data = '{32'd40, 32'd12, 32'd30, 32'd25};
    stim_blk  = '{0, 0, 0, 0};
    applyStimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] ties");
    stim_data = '{32'd7, 32'd7, 32'd3, 32'd3};
    applyStimulus(1'b0, 0, 0, 1'b0);
    stim_data = '{32'd5, 32'd5, 32'd5, 32'd5};
    applyStimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] blocked candidates");
    stim_data = '{32'd1, 32'd9, 32'd4, 32'd2};
    stim_blk  = '{1, 0, 0, 1};
    applyStimulus(1'b0, 0, 0, 1'b0);
    stim_blk  = '{1, 1, 1, 1};
    applyStimulus(1'b0, 0, 0, 1'b0);

    $display("[TB] bubbles, stalled result, stray start");
    stim_data = '{32'd60, 32'd20, 32'd20, 32'd80};
    stim_blk  = '{0, 0, 0, 0};
    applyStimulus(1'b0, 2, 5, 1'b1);

    $display("[TB] reset mid-search");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? 32'd100 : 32'd50;
      tick();
    end
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_res_valid", bus.res_valid, 0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_in_ready", bus.in_ready, 0);
    checkOutput("abort_res_idx", bus.res_idx, 0);
    checkOutput("abort_res_val", bus.res_val, 0);
    tick();
    checkOutput("abort_no_valid", bus.res_valid, 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] extreme values");
    stim_data = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
    applyStimulus(1'b0, 0, 0, 1'b0);
    stim_data = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    applyStimulus(1'b0, 1, 1, 1'b0);

    $display("[TB] mode_max request");
    stim_data = '{32'd40, 32'd12, 32'd40, 32'd25};
    applyStimulus(1'b1, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
